// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: request/duration inputs and grant/done/counter outputs of the shared timer
`timescale 1ns/1ps
interface timer_arbiter_if #(
   parameter int N = 4,
   parameter int W = 26
);
   logic [N-1:0]   req;
   logic [N*W-1:0] dur;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic           busy;
   logic [W-1:0]   count;
   modport master (output req, dur, input gnt, done, busy, count);
   modport slave  (input req, dur, output gnt, done, busy, count);
endinterface

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one down-counting interval timer between N requesters
`timescale 1ns/1ps
module timer_arbiter #(
   parameter int N = 4,
   parameter int W = 26
) (
   input logic           CLK,
   input logic           RSTN,
   timer_arbiter_if.slave bus
);
   localparam int IW = $clog2(N);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d, ptr_q, ptr_d, pick, cand, nxt;
   logic [IW:0]    sum;
   logic           found;
   logic [N-1:0]   gnt_q, gnt_d, done_q, done_d;
   logic [W-1:0]   count_q, count_d, sel_dur;
   // first requesting index at or after the round-robin pointer, wrapping mod N
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_q} + (IW+1)'(k);
         sum = (sum >= (IW+1)'(N)) ? sum - (IW+1)'(N) : sum;
         cand = sum[IW-1:0];
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end
   assign sel_dur = bus.dur[int'(pick)*W +: W];
   assign nxt     = (idx_q == IW'(N-1)) ? '0 : idx_q + IW'(1);
   // next-state and registered-output logic; done is a one-cycle pulse by default
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      count_d = count_q;
      case (state_q)
         IDLE: if (found) begin
            idx_d   = pick;
            gnt_d   = N'(1) << pick;
            count_d = sel_dur;
            state_d = (sel_dur != '0) ? RUN : DONE;
            done_d  = (sel_dur != '0) ? '0 : N'(1) << pick;
         end
         RUN: if (!bus.req[idx_q]) begin
            gnt_d   = '0;
            count_d = '0;
            state_d = IDLE;
            ptr_d   = nxt;
         end else if (count_q == W'(1)) begin
            count_d = '0;
            done_d  = gnt_q;
            state_d = DONE;
         end else begin
            count_d = count_q - W'(1);
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
            ptr_d   = nxt;
         end
      endcase
   end
   // state and output registers; reset aborts any job without a done pulse
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         count_q <= count_d;
      end
   end
   assign bus.gnt   = gnt_q;
   assign bus.done  = done_q;
   assign bus.count = count_q;
   assign bus.busy  = (state_q != IDLE);
endmodule
